// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU memory stage and
// the line-wide memory wrapper. Misses write back a dirty victim, fill, then replay as a hit.
module cache #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned SET_ADDR_LEN  = 2,
  parameter int unsigned ADDR_LEN      = 13
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                read_request,
  input  logic                                write_request,
  input  logic [31:0]                         addr,
  input  logic [31:0]                         write_data,
  output logic [31:0]                         read_data,
  output logic                                request_finish,
  output logic                                mem_read_request,
  output logic                                mem_write_request,
  output logic [31:0]                         mem_addr,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]    mem_write_data,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]    mem_read_data,
  input  logic                                mem_request_finish
);

  localparam int unsigned LineWords = 1 << LINE_ADDR_LEN;
  localparam int unsigned LineBits  = 32 * LineWords;
  localparam int unsigned Sets      = 1 << SET_ADDR_LEN;
  localparam int unsigned SetLsb    = LINE_ADDR_LEN + 2;
  localparam int unsigned TagLsb    = SetLsb + SET_ADDR_LEN;
  localparam int unsigned TagLen    = ADDR_LEN - TagLsb;

  typedef enum logic [1:0] {StReady, StSwapOut, StSwapIn, StSwapInOk} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              read_data_q, read_data_d;
  logic                     finish_q, finish_d;
  logic                     mem_rd_q, mem_rd_d;
  logic                     mem_wr_q, mem_wr_d;
  logic [31:0]              mem_addr_q, mem_addr_d;
  logic [LineBits-1:0]      mem_wdata_q, mem_wdata_d;

  logic [LineBits-1:0]      line_q [Sets];
  logic [TagLen-1:0]        tag_q [Sets];
  logic [Sets-1:0]          valid_q, dirty_q;

  logic [LINE_ADDR_LEN-1:0] offset, word_sel;
  logic [SET_ADDR_LEN-1:0]  set_idx;
  logic [TagLen-1:0]        tag;
  logic                     hit, word_we, fill_we, install;
  logic [31:0]              req_base, victim_base;
  logic                     unused_addr;

  assign offset      = addr[SetLsb-1:2];
  assign set_idx     = addr[TagLsb-1:SetLsb];
  assign tag         = addr[ADDR_LEN-1:TagLsb];
  assign unused_addr = ^{addr[31:ADDR_LEN], addr[1:0]};
  // Word 0 sits in the most significant slot, so the slot index is the inverted offset.
  assign word_sel    = ~offset;
  assign hit         = valid_q[set_idx] && (tag_q[set_idx] == tag);

  always_comb begin
    req_base    = '0;
    victim_base = '0;
    req_base[ADDR_LEN-1:SetLsb]    = {tag, set_idx};
    victim_base[ADDR_LEN-1:SetLsb] = {tag_q[set_idx], set_idx};
  end

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    finish_d    = finish_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    word_we     = 1'b0;
    fill_we     = 1'b0;
    install     = 1'b0;
    unique case (state_q)
      StReady: begin
        if (finish_q) begin
          finish_d = 1'b0;
        end else if (read_request || write_request) begin
          if (hit) begin
            finish_d = 1'b1;
            if (read_request) begin
              read_data_d = line_q[set_idx][{word_sel, 5'd0} +: 32];
            end else begin
              word_we = 1'b1;
            end
          end else if (valid_q[set_idx] && dirty_q[set_idx]) begin
            mem_addr_d  = victim_base;
            mem_wdata_d = line_q[set_idx];
            mem_wr_d    = 1'b1;
            state_d     = StSwapOut;
          end else begin
            mem_addr_d = req_base;
            mem_rd_d   = 1'b1;
            state_d    = StSwapIn;
          end
        end
      end
      StSwapOut: begin
        if (mem_request_finish) begin
          mem_wr_d   = 1'b0;
          mem_rd_d   = 1'b1;
          mem_addr_d = req_base;
          state_d    = StSwapIn;
        end
      end
      StSwapIn: begin
        if (mem_request_finish) begin
          fill_we  = 1'b1;
          mem_rd_d = 1'b0;
          state_d  = StSwapInOk;
        end
      end
      StSwapInOk: begin
        install = 1'b1;
        state_d = StReady;
      end
      default: state_d = StReady;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StReady;
      read_data_q <= '0;
      finish_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      finish_q    <= finish_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (word_we) dirty_q[set_idx] <= 1'b1;
      if (install) begin
        valid_q[set_idx] <= 1'b1;
        dirty_q[set_idx] <= 1'b0;
      end
    end
  end

  // Line data lands when the fill completes; valid is only raised one cycle later on install.
  always_ff @(posedge clk) begin
    if (word_we) line_q[set_idx][{word_sel, 5'd0} +: 32] <= write_data;
    if (fill_we) begin
      line_q[set_idx] <= mem_read_data;
      tag_q[set_idx]  <= tag;
    end
  end

  assign read_data         = read_data_q;
  assign request_finish    = finish_q;
  assign mem_read_request  = mem_rd_q;
  assign mem_write_request = mem_wr_q;
  assign mem_addr          = mem_addr_q;
  assign mem_write_data    = mem_wdata_q;

endmodule

// File: tb/tb_cache.sv
// Directed bench for cache: behavioural line-wide memory wrapper plus per-scenario tasks.
module tb_cache;
  logic         clk, rst;
  logic         read_request, write_request;
  logic [31:0]  addr, write_data, read_data, mem_addr;
  logic         request_finish, mem_read_request, mem_write_request, mem_request_finish;
  logic [255:0] mem_write_data, mem_read_data;

  int checks = 0;
  int errors = 0;
  int fills = 0, wbacks = 0, both_high = 0;
  logic [31:0]  fill_addr, wb_addr;
  logic [255:0] wb_line;
  logic [31:0]  mem [0:2047];

  cache dut (
    .clk(clk), .rst(rst), .read_request(read_request), .write_request(write_request),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .request_finish(request_finish), .mem_read_request(mem_read_request),
    .mem_write_request(mem_write_request), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_request_finish(mem_request_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mem_read_request && mem_write_request) both_high++;

  // Wrapper: completes each request three cycles after it is first seen.
  initial begin
    int cnt;
    cnt = 0;
    mem_request_finish = 1'b0;
    mem_read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mem_request_finish = 1'b0;
        cnt = 0;
      end else if (mem_request_finish) begin
        mem_request_finish = 1'b0;
        cnt = 0;
      end else if (mem_read_request || mem_write_request) begin
        cnt++;
        if (cnt == 3) begin
          if (mem_write_request) begin
            for (int i = 0; i < 8; i++) mem[mem_addr[12:2] + 11'(i)] = mem_write_data[(7-i)*32 +: 32];
            wb_addr = mem_addr;
            wb_line = mem_write_data;
            wbacks++;
          end else begin
            for (int i = 0; i < 8; i++) mem_read_data[(7-i)*32 +: 32] = mem[mem_addr[12:2] + 11'(i)];
            fill_addr = mem_addr;
            fills++;
          end
          mem_request_finish = 1'b1;
        end
      end
    end
  end

  task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdata, output int cyc);
    @(negedge clk);
    read_request = rd;
    write_request = wr;
    addr = a;
    write_data = wd;
    cyc = 0;
    while (!request_finish && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    rdata = read_data;
    if (cyc >= 200) begin
      checks++; errors++;
      $display("FAIL op_timeout addr %h: no request_finish after %0d cycles", a, cyc);
    end
    read_request = 1'b0;
    write_request = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL rst_read_data got %h want 0", read_data); end
    checks++; if (request_finish !== 1'b0) begin errors++; $display("FAIL rst_finish got %b want 0", request_finish); end
    checks++; if ({mem_read_request, mem_write_request} !== 2'b00) begin errors++; $display("FAIL rst_mem_req got %b want 00", {mem_read_request, mem_write_request}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_write_data !== 256'h0) begin errors++; $display("FAIL rst_mem_wdata got %h want 0", mem_write_data); end
    rst = 1'b0;
  endtask

  task automatic test_clean_miss;
    logic [31:0] d; int cyc, f0, w0;
    f0 = fills; w0 = wbacks;
    cpu_op(1'b1, 1'b0, 32'h10, 32'h0, d, cyc);
    checks++; if (d !== 32'hA4) begin errors++; $display("FAIL miss_data got %h want a4", d); end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL miss_latency got %0d want 6", cyc); end
    checks++; if (fill_addr !== 32'h0 || fills - f0 !== 1) begin errors++; $display("FAIL miss_fill addr %h count %0d want 0 1", fill_addr, fills - f0); end
    checks++; if (wbacks !== w0) begin errors++; $display("FAIL miss_no_wb got %0d want %0d", wbacks, w0); end
    @(negedge clk);
    checks++; if (request_finish !== 1'b0) begin errors++; $display("FAIL finish_pulse got %b want 0", request_finish); end
    checks++; if (dut.dirty_q[0] !== 1'b0) begin errors++; $display("FAIL miss_clean got %b want 0", dut.dirty_q[0]); end
  endtask

  task automatic test_read_hit;
    logic [31:0] d; int cyc, f0;
    f0 = fills;
    cpu_op(1'b1, 1'b0, 32'h14, 32'h0, d, cyc);
    checks++; if (d !== 32'hA5) begin errors++; $display("FAIL hit_data got %h want a5", d); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL hit_latency got %0d want 1", cyc); end
    checks++; if (fills !== f0) begin errors++; $display("FAIL hit_no_fill got %0d want %0d", fills, f0); end
  endtask

  task automatic test_write_hit;
    logic [31:0] d; int cyc, f0, w0;
    f0 = fills; w0 = wbacks;
    cpu_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, d, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL wr_hit_latency got %0d want 1", cyc); end
    checks++; if (dut.dirty_q[0] !== 1'b1) begin errors++; $display("FAIL wr_hit_dirty got %b want 1", dut.dirty_q[0]); end
    cpu_op(1'b1, 1'b0, 32'h10, 32'h0, d, cyc);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_hit_readback got %h want deadbeef", d); end
    checks++; if (fills !== f0 || wbacks !== w0) begin errors++; $display("FAIL wr_hit_traffic fills %0d wbs %0d want %0d %0d", fills, wbacks, f0, w0); end
  endtask

  task automatic test_dirty_miss;
    logic [31:0] d; int cyc, w0;
    w0 = wbacks;
    cpu_op(1'b1, 1'b0, 32'h90, 32'h0, d, cyc);
    checks++; if (d !== 32'hB4) begin errors++; $display("FAIL dmiss_data got %h want b4", d); end
    checks++; if (wbacks - w0 !== 1 || wb_addr !== 32'h0) begin errors++; $display("FAIL dmiss_wb count %0d addr %h want 1 0", wbacks - w0, wb_addr); end
    checks++; if (wb_line[127:96] !== 32'hDEADBEEF) begin errors++; $display("FAIL dmiss_wb_word4 got %h want deadbeef", wb_line[127:96]); end
    checks++; if (wb_line[255:224] !== 32'hA0) begin errors++; $display("FAIL dmiss_wb_word0 got %h want a0", wb_line[255:224]); end
    checks++; if (fill_addr !== 32'h80) begin errors++; $display("FAIL dmiss_fill_addr got %h want 80", fill_addr); end
    checks++; if (cyc !== 10) begin errors++; $display("FAIL dmiss_latency got %0d want 10", cyc); end
    w0 = wbacks;
    cpu_op(1'b1, 1'b0, 32'h10, 32'h0, d, cyc);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL refetch_data got %h want deadbeef", d); end
    checks++; if (wbacks !== w0 || cyc !== 6) begin errors++; $display("FAIL refetch_clean wbs %0d cyc %0d want %0d 6", wbacks, cyc, w0); end
  endtask

  task automatic test_read_write_both;
    logic [31:0] d; int cyc;
    cpu_op(1'b1, 1'b1, 32'h24, 32'h55, d, cyc);
    checks++; if (d !== 32'h10000009) begin errors++; $display("FAIL both_data got %h want 10000009", d); end
    checks++; if (dut.dirty_q[1] !== 1'b0) begin errors++; $display("FAIL both_clean got %b want 0", dut.dirty_q[1]); end
    cpu_op(1'b1, 1'b0, 32'h24, 32'h0, d, cyc);
    checks++; if (d !== 32'h10000009 || cyc !== 1) begin errors++; $display("FAIL both_reread got %h cyc %0d want 10000009 1", d, cyc); end
  endtask

  task automatic test_write_miss;
    logic [31:0] d; int cyc;
    cpu_op(1'b0, 1'b1, 32'h44, 32'h12345678, d, cyc);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL wmiss_latency got %0d want 6", cyc); end
    checks++; if (dut.dirty_q[2] !== 1'b1) begin errors++; $display("FAIL wmiss_dirty got %b want 1", dut.dirty_q[2]); end
    cpu_op(1'b1, 1'b0, 32'h44, 32'h0, d, cyc);
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL wmiss_readback got %h want 12345678", d); end
    cpu_op(1'b1, 1'b0, 32'h48, 32'h0, d, cyc);
    checks++; if (d !== 32'h10000012) begin errors++; $display("FAIL wmiss_neighbour got %h want 10000012", d); end
  endtask

  task automatic test_reset_mid_miss;
    logic [31:0] d; int cyc, n, f0;
    @(negedge clk);
    read_request = 1'b1;
    addr = 32'h64;
    n = 0;
    while (!mem_read_request && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (mem_read_request !== 1'b1) begin errors++; $display("FAIL mid_fill_start got %b want 1", mem_read_request); end
    @(negedge clk);
    rst = 1'b1;
    read_request = 1'b0;
    @(negedge clk);
    checks++; if ({mem_read_request, mem_write_request, request_finish} !== 3'b000 || mem_addr !== 32'h0)
      begin errors++; $display("FAIL mid_rst_outputs got %b addr %h want 000 0", {mem_read_request, mem_write_request, request_finish}, mem_addr); end
    rst = 1'b0;
    f0 = fills;
    cpu_op(1'b1, 1'b0, 32'h10, 32'h0, d, cyc);
    checks++; if (fills - f0 !== 1 || cyc !== 6) begin errors++; $display("FAIL mid_rst_remiss fills %0d cyc %0d want 1 6", fills - f0, cyc); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_rst_data got %h want deadbeef", d); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h10000000 + 32'(i);
    for (int i = 0; i < 8; i++) begin
      mem[i] = 32'hA0 + 32'(i);
      mem[32 + i] = 32'hB0 + 32'(i);
    end
    read_request = 1'b0;
    write_request = 1'b0;
    addr = '0;
    write_data = '0;
    test_reset;
    test_clean_miss;
    test_read_hit;
    test_write_hit;
    test_dirty_miss;
    test_read_write_both;
    test_write_miss;
    test_reset_mid_miss;
    checks++; if (both_high !== 0) begin errors++; $display("FAIL mem_req_exclusive got %0d want 0", both_high); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
